// File: rtl/req_onehot_arbiter_if.sv
// Purpose: request/grant bundle between the arbiter and its requesters/encoder.
// Ports: req, grant_ready into the arbiter; grant, grant_valid, pending, pend_cnt out of it.
// master = arbiter side, slave = requester/consumer side.
interface req_onehot_arbiter_if;
    logic [7:0] req;
    logic [7:0] grant;
    logic       grant_valid;
    logic       grant_ready;
    logic [7:0] pending;
    logic [3:0] pend_cnt;

    modport master (
        input  req,
        input  grant_ready,
        output grant,
        output grant_valid,
        output pending,
        output pend_cnt
    );

    modport slave (
        output req,
        output grant_ready,
        input  grant,
        input  grant_valid,
        input  pending,
        input  pend_cnt
    );
endinterface

// File: rtl/req_onehot_arbiter.sv
// Purpose: sticky 8-line request capture + round-robin arbiter giving a registered one-hot grant.
// Latency: req edge k -> pending after k -> grant after k+1; one idle cycle between grants.
// Backpressure: grant held stable (same winner) while grant_ready=0; ready ignored when not valid.
// Ports: clk, rst_n (sync, active-low); bus (master modport): req, grant_ready in;
//        grant, grant_valid, pending, pend_cnt out (all registered).
module req_onehot_arbiter #(
    parameter int N = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    req_onehot_arbiter_if.master  bus
);

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_GNT  = 1'b1
    } state_t;

    state_t         r_state;
    state_t         w_state_nxt;
    logic [N-1:0]   r_pending;
    logic [N-1:0]   w_pending_nxt;
    logic [N-1:0]   r_grant;
    logic [N-1:0]   w_grant_nxt;
    logic [N-1:0]   w_clr;
    logic           r_grant_valid;
    logic           w_grant_valid_nxt;
    logic [3:0]     r_pend_cnt;
    logic [3:0]     w_pend_cnt_nxt;
    logic [2:0]     r_last;
    logic [2:0]     w_last_nxt;
    logic [2:0]     r_win;
    logic [2:0]     w_win_nxt;
    logic [2:0]     w_sel;
    logic           w_sel_found;

    // Rotating priority search: start one above the last winner, wrap through 7->0.
    // The 3-bit sum wraps naturally, so k=8 revisits last itself with lowest priority.
    // Only registered pending bits are eligible; fresh req waits a cycle.
    always_comb begin
        w_sel       = '0;
        w_sel_found = 1'b0;
        for (int k = 1; k <= N; k++) begin
            if (!w_sel_found && r_pending[3'(r_last + 3'(k))]) begin
                w_sel       = 3'(r_last + 3'(k));
                w_sel_found = 1'b1;
            end
        end
    end

    // Next-state / output logic.
    always_comb begin
        w_state_nxt       = r_state;
        w_grant_nxt       = r_grant;
        w_grant_valid_nxt = r_grant_valid;
        w_last_nxt        = r_last;
        w_win_nxt         = r_win;
        w_clr             = '0;
        case (r_state)
            ST_IDLE: begin
                if (w_sel_found) begin
                    w_grant_nxt       = {{(N-1){1'b0}}, 1'b1} << w_sel;
                    w_grant_valid_nxt = 1'b1;
                    w_win_nxt         = w_sel;
                    w_state_nxt       = ST_GNT;
                end
            end
            ST_GNT: begin
                // Winner is frozen until accepted, even if higher-priority bits arrive.
                if (bus.grant_ready) begin
                    w_clr             = r_grant;
                    w_last_nxt        = r_win;
                    w_grant_nxt       = '0;
                    w_grant_valid_nxt = 1'b0;
                    w_state_nxt       = ST_IDLE;
                end
            end
            default: begin
                w_grant_nxt       = '0;
                w_grant_valid_nxt = 1'b0;
                w_state_nxt       = ST_IDLE;
            end
        endcase
        // Set wins over clear: a re-request on the accept edge keeps the bit pending.
        w_pending_nxt = (r_pending & ~w_clr) | bus.req;
    end

    // Popcount of the next pending vector, registered alongside it.
    always_comb begin
        w_pend_cnt_nxt = '0;
        for (int i = 0; i < N; i++) begin
            w_pend_cnt_nxt = w_pend_cnt_nxt + {3'b000, w_pending_nxt[i]};
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state       <= ST_IDLE;
            r_pending     <= '0;
            r_pend_cnt    <= '0;
            r_grant       <= '0;
            r_grant_valid <= 1'b0;
            r_last        <= 3'd7;
            r_win         <= 3'd0;
        end else begin
            r_state       <= w_state_nxt;
            r_pending     <= w_pending_nxt;
            r_pend_cnt    <= w_pend_cnt_nxt;
            r_grant       <= w_grant_nxt;
            r_grant_valid <= w_grant_valid_nxt;
            r_last        <= w_last_nxt;
            r_win         <= w_win_nxt;
        end
    end

    assign bus.grant       = r_grant;
    assign bus.grant_valid = r_grant_valid;
    assign bus.pending     = r_pending;
    assign bus.pend_cnt    = r_pend_cnt;

endmodule

// File: doc/req_onehot_arbiter.md
Name: req_onehot_arbiter

Overview:
- Upstream stage of the 8-to-3 one-hot encoder.
- Captures up to 8 request lines into sticky pending bits.
- Arbitrates among them round-robin and presents exactly one granted request as a registered one-hot vector, held under a valid/ready handshake.
- Guarantees the downstream encoder only ever sees a legal one-hot code or all-zeros, never a multi-hot vector.

Parameters:
- N, 8, number of request lines. Fixed at 8 to match the 3-bit encoder. Other values are unsupported.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  synchronous active-low reset, sampled on rising clk
- req  input  8  request lines; a bit sampled high on any edge sets its pending bit
- grant  output  8  registered one-hot grant; 8'b0000_0000 when grant_valid=0; drives encoder input I
- grant_valid  output  1  grant holds a valid one-hot value
- grant_ready  input  1  consumer accepts grant this cycle
- pending  output  8  registered sticky pending bits
- pend_cnt  output  4  registered popcount of pending, range 0..8

Behaviour:
- Reset (rst_n=0 at edge):
  - pending=0, grant=0, grant_valid=0, pend_cnt=0.
  - Round-robin pointer last=7, so bit 0 has the highest priority first.
  - FSM=IDLE.
  - Reset overrides all other activity, including a grant in flight. Requests sampled on the reset edge are dropped.
- Pending update each edge: pending_next = (pending & ~clr) | req.
  - clr is the one-hot grant when grant_valid & grant_ready, else 0.
  - Set wins: if req[i] is high on the same edge that bit i is accepted, pending[i] stays 1.
  - pend_cnt = popcount(pending_next), registered together with pending.
- FSM states:
  - IDLE: grant_valid=0, grant=0. If pending!=0 (registered value), at the next edge select winner w, load grant=(1<<w), grant_valid=1, go to GNT. Else stay in IDLE.
  - GNT: grant and grant_valid are held stable while grant_ready=0 (no retraction, no change of winner even if higher-priority requests arrive). On an edge with grant_ready=1: clear pending[w], set last=w, grant=0, grant_valid=0, go to IDLE.
- Winner selection: the first set bit of pending searching upward from (last+1) mod 8, wrapping past bit 7 to bit 0. Only pending bits already registered are considered; a req arriving in the same cycle is not eligible until the next cycle.
- Latency:
  - req high at edge k -> pending[i]=1 after edge k -> grant_valid=1 after edge k+1, if IDLE.
  - Accept at edge m -> IDLE after m -> next grant earliest after edge m+1. One bubble cycle between consecutive grants; peak throughput is 1 grant per 2 cycles.
- grant_ready is ignored when grant_valid=0.
- All 8 pending with continuous ready: grant order 0,1,...,7, then wraps.
- Starvation-free: any pending bit is granted within 8 grants.

Test Plan:
- Reset mid-grant: with grant=8'h04 and grant_valid=1, assert rst_n=0 for one edge -> next cycle grant=0, grant_valid=0, pending=0, pend_cnt=0. Then req=8'h01 -> grant=8'h01 two edges later.
- Single request latency: one-cycle pulse req=8'h20 at edge k -> pending=8'h20 and pend_cnt=1 after k; grant=8'h20 and grant_valid=1 after k+1. Hold ready=0 for 5 cycles -> grant stays 8'h20. Ready=1 -> pending=0, grant_valid=0.
- Round-robin wrap: preload pending=8'hFF, ready tied to 1 -> grant sequence 01,02,04,08,10,20,40,80, then idle. pend_cnt steps 8->7->...->0, each grant separated by one idle cycle.
- Pointer fairness: last=2 (bit 2 just granted), pending=8'h05 -> next grant=8'h01 (bit 0 after wrap, not bit 2). A further req on bit 1 arriving during that grant -> next grant=8'h02 before bit 2 is regranted.
- Simultaneous set and clear: grant=8'h08 in GNT, ready=1, and req=8'h08 on the same edge -> pending[3] stays 1, pend_cnt unchanged. Bit 3 is regranted only after the other pending bits, per pointer order.
- Hold stability: grant=8'h10 with ready=0; raise req=8'h01 -> grant stays 8'h10, pending becomes 8'h11. After accept -> next grant=8'h01 (search from bit 5 wraps to bit 0).
